// File: rtl/picorv32_freeahb_bridge_pkg.sv
// picorv_ahb_pkg: shared types and helpers for the PicoRV32 to FreeAHB bridge.
//   state_t          bridge FSM states
//   HSIZE_*          FreeAHB transfer size codes
//   PROT_*           FreeAHB protection codes (instruction fetch / data)
//   bswap32()        reverses the byte order of a 32-bit word
package picorv_ahb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_PLAN,
    WR_ADDR,
    WR_DATA,
    WR_DONE,
    ACK
  } state_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [3:0] PROT_INSTR = 4'b0000;
  localparam logic [3:0] PROT_DATA  = 4'b0001;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/picorv32_freeahb_bridge_if.sv
// picorv32_freeahb_bridge_if: PicoRV32 native memory port plus FreeAHB master
// user interface, bundled as seen by the bridge.
//   master : the bridge (answers the core, issues FreeAHB transfers)
//   slave  : the environment (the core requesting, the FreeAHB master answering)
// mem_*      : mem_valid/instr/addr/wdata/wstrb in, mem_ready/rdata out (bridge view)
// freeahb_*  : addr/wdata/size/read/write/valid/min_len/cont/lock/prot out,
//              next/ready/rdata/result_addr in (bridge view)
interface picorv32_freeahb_bridge_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [31:0] freeahb_addr;
  logic [31:0] freeahb_wdata;
  logic [2:0]  freeahb_size;
  logic        freeahb_read;
  logic        freeahb_write;
  logic        freeahb_valid;
  logic [31:0] freeahb_min_len;
  logic        freeahb_cont;
  logic        freeahb_lock;
  logic [3:0]  freeahb_prot;
  logic        freeahb_next;
  logic        freeahb_ready;
  logic [31:0] freeahb_rdata;
  logic [31:0] freeahb_result_addr;

  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output freeahb_addr, freeahb_wdata, freeahb_size, freeahb_read,
    output freeahb_write, freeahb_valid, freeahb_min_len, freeahb_cont,
    output freeahb_lock, freeahb_prot,
    input  freeahb_next, freeahb_ready, freeahb_rdata, freeahb_result_addr
  );

  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  freeahb_addr, freeahb_wdata, freeahb_size, freeahb_read,
    input  freeahb_write, freeahb_valid, freeahb_min_len, freeahb_cont,
    input  freeahb_lock, freeahb_prot,
    output freeahb_next, freeahb_ready, freeahb_rdata, freeahb_result_addr
  );
endinterface

// File: rtl/picorv32_freeahb_bridge_strb_planner.sv
// picorv_ahb_strb_planner: picks the next AHB write transfer for a strobe
// pattern, looking at byte offset o of the captured word.
//   wstrb  in  4  captured write strobes
//   offset in  3  current byte offset o (0..4)
//   size   out 3  HSIZE code of the transfer at o
//   bytes  out 3  bytes covered by that transfer
//   skip   out 1  no strobe at o; advance by one byte
//   done   out 1  o has passed the last lane
module picorv_ahb_strb_planner
  import picorv_ahb_pkg::*;
#(
  parameter bit MERGE_STROBES = 1'b1
) (
  input  logic [3:0] wstrb,
  input  logic [2:0] offset,
  output logic [2:0] size,
  output logic [2:0] bytes,
  output logic       skip,
  output logic       done
);

  logic [1:0] lane;
  logic       cur;
  logic       pair;

  assign lane = offset[1:0];
  assign cur  = wstrb[lane];
  // Upper byte of the halfword starting at an even lane.
  assign pair = wstrb[{lane[1], 1'b1}];

  always_comb begin
    size  = HSIZE_BYTE;
    bytes = 3'd1;
    skip  = 1'b0;
    done  = 1'b0;
    if (offset[2]) begin
      done = 1'b1;
    end else if (MERGE_STROBES && (offset == 3'd0) && (wstrb == 4'b1111)) begin
      size  = HSIZE_WORD;
      bytes = 3'd4;
    end else if (MERGE_STROBES && !lane[0] && cur && pair) begin
      size  = HSIZE_HALF;
      bytes = 3'd2;
    end else if (!cur) begin
      skip = 1'b1;
    end
  end

endmodule

// File: rtl/picorv32_freeahb_bridge.sv
// picorv32_freeahb_bridge: PicoRV32 native memory port to FreeAHB master user
// interface. Writes are split into the fewest naturally aligned transfers;
// read data is registered.
//   clk     in  single clock, rising edge
//   resetn  in  asynchronous active-low reset
//   bus     picorv32_freeahb_bridge_if.master (core side and FreeAHB side)
// Parameters: BIG_ENDIAN_AHB (AHB lane order), MERGE_STROBES (allow half/word).
// Build option: PICORV_AHB_POSTED_WRITE_EN releases the core one cycle after a
// write is captured; the transfers then run in the background.
//
// state   | meaning
// IDLE    | waiting for mem_valid
// RD_REQ  | read address phase, waiting for freeahb_next
// RD_RESP | waiting for freeahb_ready, then register read data
// WR_PLAN | choose transfer at offset o, skip empty lanes, or finish
// WR_ADDR | write address phase, waiting for freeahb_next
// WR_DATA | write data phase, waiting for freeahb_next
// WR_DONE | one-cycle gap before planning the next transfer
// ACK     | mem_ready pulse
module picorv32_freeahb_bridge
  import picorv_ahb_pkg::*;
#(
  parameter bit BIG_ENDIAN_AHB = 1'b1,
  parameter bit MERGE_STROBES  = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  picorv32_freeahb_bridge_if.master bus
);

  state_t      state, state_nxt;
  logic [2:0]  off, off_nxt;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_instr;
  logic [31:0] rdata_q;
  logic        capture;
  logic        load_rdata;
  logic        ack_pulse;

  logic [2:0]  pl_size;
  logic [2:0]  pl_bytes;
  logic        pl_skip;
  logic        pl_done;

  logic [31:0] unused_result_addr;
  assign unused_result_addr = bus.freeahb_result_addr;

  picorv_ahb_strb_planner #(.MERGE_STROBES(MERGE_STROBES)) u_planner (
    .wstrb  (cap_wstrb),
    .offset (off),
    .size   (pl_size),
    .bytes  (pl_bytes),
    .skip   (pl_skip),
    .done   (pl_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      off       <= 3'd0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_wstrb <= 4'd0;
      cap_instr <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      off   <= off_nxt;
      if (capture) begin
        cap_addr  <= {bus.mem_addr[31:2], 2'b00};
        cap_wdata <= bus.mem_wdata;
        cap_wstrb <= bus.mem_wstrb;
        cap_instr <= bus.mem_instr;
      end
      if (load_rdata) begin
        rdata_q <= BIG_ENDIAN_AHB ? bswap32(bus.freeahb_rdata) : bus.freeahb_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    off_nxt    = off;
    capture    = 1'b0;
    load_rdata = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_valid) begin
          capture   = 1'b1;
          off_nxt   = 3'd0;
          state_nxt = (bus.mem_wstrb == 4'd0) ? RD_REQ : WR_PLAN;
        end
      end
      RD_REQ:  if (bus.freeahb_next) state_nxt = RD_RESP;
      RD_RESP: begin
        if (bus.freeahb_ready) begin
          load_rdata = 1'b1;
          state_nxt  = ACK;
        end
      end
      WR_PLAN: begin
        if (pl_done) begin
`ifdef PICORV_AHB_POSTED_WRITE_EN
          state_nxt = IDLE;
`else
          state_nxt = ACK;
`endif
        end else if (pl_skip) begin
          off_nxt = off + 3'd1;
        end else begin
          state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: if (bus.freeahb_next) state_nxt = WR_DATA;
      WR_DATA: begin
        if (bus.freeahb_next) begin
          off_nxt   = off + pl_bytes;
          state_nxt = WR_DONE;
        end
      end
      WR_DONE: state_nxt = WR_PLAN;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PICORV_AHB_POSTED_WRITE_EN
  // Write completion is signalled as soon as the request is buffered.
  logic posted_ack;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) posted_ack <= 1'b0;
    else         posted_ack <= capture && (bus.mem_wstrb != 4'd0);
  end
  assign ack_pulse = posted_ack || (state == ACK);
`else
  assign ack_pulse = (state == ACK);
`endif

  assign bus.mem_ready       = ack_pulse;
  assign bus.mem_rdata       = rdata_q;
  assign bus.freeahb_min_len = 32'd0;
  assign bus.freeahb_cont    = 1'b0;
  assign bus.freeahb_lock    = 1'b0;

  // Outputs are a pure function of state so reset clears them at once.
  always_comb begin
    bus.freeahb_addr  = 32'd0;
    bus.freeahb_wdata = 32'd0;
    bus.freeahb_size  = HSIZE_BYTE;
    bus.freeahb_read  = 1'b0;
    bus.freeahb_write = 1'b0;
    bus.freeahb_valid = 1'b0;
    bus.freeahb_prot  = 4'd0;
    case (state)
      RD_REQ: begin
        bus.freeahb_addr = cap_addr;
        bus.freeahb_size = HSIZE_WORD;
        bus.freeahb_read = 1'b1;
        bus.freeahb_prot = cap_instr ? PROT_INSTR : PROT_DATA;
      end
      WR_ADDR, WR_DATA: begin
        bus.freeahb_addr  = cap_addr + {29'd0, off};
        bus.freeahb_size  = pl_size;
        bus.freeahb_write = 1'b1;
        bus.freeahb_prot  = cap_instr ? PROT_INSTR : PROT_DATA;
        if (state == WR_DATA) begin
          // Whole word goes out; the slave picks lanes from addr and size.
          bus.freeahb_wdata = BIG_ENDIAN_AHB ? bswap32(cap_wdata) : cap_wdata;
          bus.freeahb_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picorv32_freeahb_bridge.sv
module tb_picorv32_freeahb_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  picorv32_freeahb_bridge_if bus();
  picorv32_freeahb_bridge_if bus_b();

  picorv32_freeahb_bridge #(.BIG_ENDIAN_AHB(1'b1), .MERGE_STROBES(1'b1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  picorv32_freeahb_bridge #(.BIG_ENDIAN_AHB(1'b0), .MERGE_STROBES(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b)
  );

  // FreeAHB responder for dut: next after wait_a stall cycles per phase,
  // ready one cycle after a read handshake.
  int   wait_a = 0;
  int   wc_a;
  logic ready_a;
  logic [31:0] rdata_a = 32'd0;
  assign bus.freeahb_next        = (bus.freeahb_read | bus.freeahb_write) && (wc_a >= wait_a);
  assign bus.freeahb_ready       = ready_a;
  assign bus.freeahb_rdata       = rdata_a;
  assign bus.freeahb_result_addr = 32'd0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wc_a <= 0; ready_a <= 1'b0;
    end else begin
      wc_a    <= ((bus.freeahb_read | bus.freeahb_write) && !bus.freeahb_next) ? wc_a + 1 : 0;
      ready_a <= bus.freeahb_read && bus.freeahb_next;
    end
  end

  logic ready_b;
  assign bus_b.freeahb_next        = bus_b.freeahb_read | bus_b.freeahb_write;
  assign bus_b.freeahb_ready       = ready_b;
  assign bus_b.freeahb_rdata       = 32'd0;
  assign bus_b.freeahb_result_addr = 32'd0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) ready_b <= 1'b0;
    else         ready_b <= bus_b.freeahb_read && bus_b.freeahb_next;
  end

  // Transfer logs, sampled on the falling edge.
  logic [31:0] xa_addr[$], xa_wdata[$], xb_addr[$], xb_wdata[$];
  logic [2:0]  xa_size[$], xb_size[$];
  int   rdy_cnt_a = 0;
  int   last_wr_cyc = 0;
  int   rd_rise_cyc = 0;
  logic rd_prev = 1'b0;
  logic [31:0] rd_addr_seen = 32'd0;
  logic [2:0]  rd_size_seen = 3'd0;
  logic [3:0]  rd_prot_seen = 4'd0;
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.freeahb_valid && bus.freeahb_next) begin
        xa_addr.push_back(bus.freeahb_addr);
        xa_size.push_back(bus.freeahb_size);
        xa_wdata.push_back(bus.freeahb_wdata);
        last_wr_cyc = cyc;
      end
      if (bus.freeahb_read && !rd_prev) rd_rise_cyc = cyc;
      if (bus.freeahb_read && bus.freeahb_next) begin
        rd_addr_seen = bus.freeahb_addr;
        rd_size_seen = bus.freeahb_size;
        rd_prot_seen = bus.freeahb_prot;
      end
      if (bus.mem_ready) rdy_cnt_a++;
      rd_prev = bus.freeahb_read;
      if (bus_b.freeahb_valid && bus_b.freeahb_next) begin
        xb_addr.push_back(bus_b.freeahb_addr);
        xb_size.push_back(bus_b.freeahb_size);
        xb_wdata.push_back(bus_b.freeahb_wdata);
      end
    end else begin
      rd_prev = 1'b0;
    end
  end

  task automatic cpu_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic ins, output int lat, output int rcyc);
    bus.mem_addr = a; bus.mem_wdata = wd; bus.mem_wstrb = ws; bus.mem_instr = ins;
    bus.mem_valid = 1'b1;
    lat = 0; rcyc = 0;
    forever begin
      @(negedge clk); lat++;
      if (bus.mem_ready) begin rcyc = cyc; break; end
      if (lat >= 300) begin
        vectors++; miscompares++;
        $display("FAIL req_timeout addr=%h: no mem_ready, required one within 300 cycles", a);
        break;
      end
    end
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.mem_ready, bus.mem_rdata, bus.freeahb_addr, bus.freeahb_wdata, bus.freeahb_size,
         bus.freeahb_read, bus.freeahb_write, bus.freeahb_valid, bus.freeahb_min_len,
         bus.freeahb_cont, bus.freeahb_lock, bus.freeahb_prot} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h addr=%h rd=%b wr=%b v=%b prot=%b, required all 0",
               bus.mem_ready, bus.mem_rdata, bus.freeahb_addr, bus.freeahb_read,
               bus.freeahb_write, bus.freeahb_valid, bus.freeahb_prot);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat, rc, r0;
    rdata_a = 32'h1122_3344;
    r0 = rdy_cnt_a;
    cpu_req(32'h0000_1000, 32'd0, 4'd0, 1'b0, lat, rc);
    vectors++;
    if (bus.mem_rdata !== 32'h4433_2211) begin
      miscompares++; $display("FAIL read_be_data: got %h required %h", bus.mem_rdata, 32'h4433_2211);
    end
    vectors++;
    if (rd_prot_seen !== 4'b0001 || rd_addr_seen !== 32'h1000 || rd_size_seen !== 3'd2) begin
      miscompares++;
      $display("FAIL read_phase: got prot=%b addr=%h size=%0d required 0001/00001000/2",
               rd_prot_seen, rd_addr_seen, rd_size_seen);
    end
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL read_latency_nowait: got %0d required 3", lat); end
    repeat (3) @(negedge clk);
    vectors++;
    if (rdy_cnt_a - r0 !== 1) begin
      miscompares++; $display("FAIL read_one_pulse: got %0d pulses required 1", rdy_cnt_a - r0);
    end
    // Instruction fetch with a two-cycle stall on next.
    wait_a = 2;
    rdata_a = 32'hCAFE_F00D;
    cpu_req(32'h0000_2004, 32'd0, 4'd0, 1'b1, lat, rc);
    wait_a = 0;
    vectors++;
    if (bus.mem_rdata !== 32'h0DF0_FECA || rd_prot_seen !== 4'b0000 || rd_addr_seen !== 32'h2004) begin
      miscompares++;
      $display("FAIL read_instr: got rdata=%h prot=%b addr=%h required 0df0feca/0000/00002004",
               bus.mem_rdata, rd_prot_seen, rd_addr_seen);
    end
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL read_latency_wait2: got %0d required 5", lat); end
    @(negedge clk);
  endtask

  task automatic test_write_word();
    int lat, rc, n0, r0;
    n0 = xa_addr.size(); r0 = rdy_cnt_a;
    cpu_req(32'h0000_3000, 32'hAABB_CCDD, 4'b1111, 1'b0, lat, rc);
    repeat (20) @(negedge clk);
    vectors++;
    if (xa_addr.size() - n0 !== 1) begin
      miscompares++; $display("FAIL word_count: got %0d transfers required 1", xa_addr.size() - n0);
    end else begin
      vectors++;
      if (xa_addr[n0] !== 32'h3000 || xa_size[n0] !== 3'd2 || xa_wdata[n0] !== 32'hDDCC_BBAA) begin
        miscompares++;
        $display("FAIL word_xfer: got addr=%h size=%0d wdata=%h required 00003000/2/ddccbbaa",
                 xa_addr[n0], xa_size[n0], xa_wdata[n0]);
      end
    end
    vectors++;
    if (rdy_cnt_a - r0 !== 1) begin
      miscompares++; $display("FAIL word_one_pulse: got %0d required 1", rdy_cnt_a - r0);
    end
    vectors++;
    if (bus.mem_rdata !== 32'h0DF0_FECA) begin
      miscompares++; $display("FAIL rdata_hold: got %h required 0df0feca", bus.mem_rdata);
    end
  endtask

  task automatic test_write_merge();
    logic [31:0] t_addr [4] = '{32'h2000, 32'h7000, 32'h4000, 32'h4100};
    logic [31:0] t_wd   [4] = '{32'h1122_3344, 32'hCAFE_BABE, 32'h0123_4567, 32'h89AB_CDEF};
    logic [31:0] t_exw  [4] = '{32'h4433_2211, 32'hBEBA_FECA, 32'h6745_2301, 32'hEFCD_AB89};
    logic [3:0]  t_ws   [4] = '{4'b0101, 4'b0111, 4'b1100, 4'b0110};
    int          t_n    [4] = '{2, 2, 1, 2};
    logic [31:0] t_a0   [4] = '{32'h2000, 32'h7000, 32'h4002, 32'h4101};
    logic [2:0]  t_s0   [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
    logic [31:0] t_a1   [4] = '{32'h2002, 32'h7002, 32'h0, 32'h4102};
    logic [2:0]  t_s1   [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
    int lat, rc, n0;
    for (int i = 0; i < 4; i++) begin
      n0 = xa_addr.size();
      cpu_req(t_addr[i], t_wd[i], t_ws[i], 1'b0, lat, rc);
      repeat (20) @(negedge clk);
      vectors++;
      if (xa_addr.size() - n0 !== t_n[i]) begin
        miscompares++;
        $display("FAIL merge_count[%0d]: got %0d transfers required %0d", i, xa_addr.size() - n0, t_n[i]);
        continue;
      end
      vectors++;
      if (xa_addr[n0] !== t_a0[i] || xa_size[n0] !== t_s0[i] || xa_wdata[n0] !== t_exw[i]) begin
        miscompares++;
        $display("FAIL merge_first[%0d]: got addr=%h size=%0d wdata=%h required %h/%0d/%h",
                 i, xa_addr[n0], xa_size[n0], xa_wdata[n0], t_a0[i], t_s0[i], t_exw[i]);
      end
      if (t_n[i] == 2) begin
        vectors++;
        if (xa_addr[n0+1] !== t_a1[i] || xa_size[n0+1] !== t_s1[i] || xa_wdata[n0+1] !== t_exw[i]) begin
          miscompares++;
          $display("FAIL merge_second[%0d]: got addr=%h size=%0d wdata=%h required %h/%0d/%h",
                   i, xa_addr[n0+1], xa_size[n0+1], xa_wdata[n0+1], t_a1[i], t_s1[i], t_exw[i]);
        end
      end
    end
  endtask

  task automatic test_no_merge();
    logic [31:0] ea [3] = '{32'h5000, 32'h5001, 32'h5002};
    int n;
    bus_b.mem_addr = 32'h5000; bus_b.mem_wdata = 32'h0102_0304;
    bus_b.mem_wstrb = 4'b0111; bus_b.mem_instr = 1'b0; bus_b.mem_valid = 1'b1;
    n = 0;
    while (!bus_b.mem_ready && n < 300) begin @(negedge clk); n++; end
    bus_b.mem_valid = 1'b0; bus_b.mem_wstrb = 4'd0;
    vectors++;
    if (n >= 300) begin
      miscompares++; $display("FAIL nomerge_timeout: no mem_ready within 300 cycles");
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (xb_addr.size() !== 3) begin
      miscompares++; $display("FAIL nomerge_count: got %0d transfers required 3", xb_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (xb_addr[i] !== ea[i] || xb_size[i] !== 3'd0 || xb_wdata[i] !== 32'h0102_0304) begin
          miscompares++;
          $display("FAIL nomerge_xfer[%0d]: got addr=%h size=%0d wdata=%h required %h/0/01020304",
                   i, xb_addr[i], xb_size[i], xb_wdata[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, wr_rc, rd_rc, n0;
    n0 = xa_addr.size();
    wait_a = 1;
    rdata_a = 32'h9ABC_DEF0;
    cpu_req(32'h0000_6000, 32'h1234_5678, 4'b0011, 1'b0, lat, wr_rc);
    cpu_req(32'h0000_6000, 32'd0, 4'd0, 1'b0, lat, rd_rc);
    wait_a = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (xa_addr.size() - n0 !== 1 || xa_size[n0] !== 3'd1 || xa_addr[n0] !== 32'h6000) begin
      miscompares++;
      $display("FAIL b2b_write: got %0d transfers (first size=%0d) required 1 halfword at 00006000",
               xa_addr.size() - n0, xa_size[n0]);
    end
`ifdef PICORV_AHB_POSTED_WRITE_EN
    vectors++;
    if (!(wr_rc < last_wr_cyc)) begin
      miscompares++;
      $display("FAIL posted_early_ready: ready cycle %0d, last data cycle %0d, required ready before", wr_rc, last_wr_cyc);
    end
`else
    vectors++;
    if (!(wr_rc > last_wr_cyc)) begin
      miscompares++;
      $display("FAIL write_late_ready: ready cycle %0d, last data cycle %0d, required ready after", wr_rc, last_wr_cyc);
    end
`endif
    vectors++;
    if (!(rd_rise_cyc > last_wr_cyc)) begin
      miscompares++;
      $display("FAIL read_after_write: read rose at %0d, write data at %0d, required read later", rd_rise_cyc, last_wr_cyc);
    end
    vectors++;
    if (bus.mem_rdata !== 32'hF0DE_BC9A) begin
      miscompares++; $display("FAIL b2b_read_data: got %h required f0debc9a", bus.mem_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int n, n0, lat, rc;
    n0 = xa_addr.size();
    wait_a = 3;
    bus.mem_addr = 32'h0000_8000; bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_wstrb = 4'b1111; bus.mem_instr = 1'b0; bus.mem_valid = 1'b1;
    n = 0;
    while (!bus.freeahb_valid && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 50) begin miscompares++; $display("FAIL rst_mid_no_wrdata: WR_DATA not reached in 50 cycles"); end
    resetn = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.mem_ready, bus.mem_rdata, bus.freeahb_addr, bus.freeahb_wdata, bus.freeahb_size,
         bus.freeahb_read, bus.freeahb_write, bus.freeahb_valid, bus.freeahb_prot} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got rdata=%h addr=%h wr=%b v=%b required all 0",
               bus.mem_rdata, bus.freeahb_addr, bus.freeahb_write, bus.freeahb_valid);
    end
    wait_a = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rdata_a = 32'h5566_7788;
    cpu_req(32'h0000_0040, 32'd0, 4'd0, 1'b0, lat, rc);
    vectors++;
    if (bus.mem_rdata !== 32'h8877_6655 || lat !== 3) begin
      miscompares++;
      $display("FAIL rst_mid_recover: got rdata=%h lat=%0d required 88776655/3", bus.mem_rdata, lat);
    end
    vectors++;
    if (xa_addr.size() !== n0) begin
      miscompares++; $display("FAIL rst_mid_aborted: got %0d extra transfers required 0", xa_addr.size() - n0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = 32'd0;
    bus.mem_wdata = 32'd0; bus.mem_wstrb = 4'd0;
    bus_b.mem_valid = 1'b0; bus_b.mem_instr = 1'b0; bus_b.mem_addr = 32'd0;
    bus_b.mem_wdata = 32'd0; bus_b.mem_wstrb = 4'd0;
    test_reset();
    test_read();
    test_write_word();
    test_write_merge();
    test_no_merge();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
